// File: rtl/mii_tx_framer.sv
// mii_tx_framer -- transmit-side MII framer.
// Takes a byte stream (valid/ready with a last flag) and drives a 4-bit MII
// transmit interface: 15 preamble nibbles, SFD, data low nibble first, zero
// pad up to MIN_FRAME bytes, CRC-32 FCS, then IFG_NIBBLES idle nibble-times.
// A missing byte (underrun) or a frame longer than MAX_FRAME is aborted with a
// single phy_tx_err cycle followed by the normal inter-frame gap.
//
// Ports:
//   clk         PHY tx clock, one nibble per cycle
//   rst         synchronous active-high reset
//   tx_data     byte to transmit
//   tx_valid    tx_data/tx_last valid
//   tx_last     current byte is the final data byte of the frame
//   tx_ready    byte accepted on this cycle's edge when tx_valid && tx_ready
//   phy_tx_en   MII transmit enable
//   phy_txd     MII transmit nibble
//   phy_tx_err  MII transmit error (only in the abort cycle)
//   busy        high in every state except IDLE
module mii_tx_framer #(
  parameter int MIN_FRAME   = 60,
  parameter int MAX_FRAME   = 1514,
  parameter int IFG_NIBBLES = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       phy_tx_en,
  output logic [3:0] phy_txd,
  output logic       phy_tx_err,
  output logic       busy
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PRE   = 4'd1;
  localparam logic [3:0] S_SFD   = 4'd2;
  localparam logic [3:0] S_DLO   = 4'd3;
  localparam logic [3:0] S_DHI   = 4'd4;
  localparam logic [3:0] S_PAD   = 4'd5;
  localparam logic [3:0] S_FCS   = 4'd6;
  localparam logic [3:0] S_ABORT = 4'd7;
  localparam logic [3:0] S_IFG   = 4'd8;

  localparam logic [10:0] MIN_C    = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_C    = 11'(MAX_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

  logic [3:0]  state;
  logic [7:0]  byte_q;
  logic        last_q;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic [15:0] cnt;
  logic [31:0] crc;
  logic        pad_hi;

  // Reflected CRC-32, one nibble per call, bit 0 first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  // Every output is a register; each branch below loads the values that the
  // next cycle presents on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_ready   <= 1'b0;
      phy_tx_en  <= 1'b0;
      phy_txd    <= 4'h0;
      phy_tx_err <= 1'b0;
      busy       <= 1'b0;
      crc        <= 32'hFFFFFFFF;
      byte_cnt   <= 11'd0;
      cnt        <= 16'd0;
      byte_q     <= 8'h00;
      last_q     <= 1'b0;
      pad_hi     <= 1'b0;
    end else begin
      tx_ready   <= 1'b0;
      phy_tx_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            state     <= S_PRE;
            phy_tx_en <= 1'b1;
            phy_txd   <= 4'h5;
            busy      <= 1'b1;
            cnt       <= 16'd0;
            crc       <= 32'hFFFFFFFF;
            byte_cnt  <= 11'd0;
          end
        end
        S_PRE: begin
          if (cnt == 16'd14) begin
            state    <= S_SFD;
            phy_txd  <= 4'hD;
            tx_ready <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DLO: begin
          state    <= S_DHI;
          phy_txd  <= byte_q[7:4];
          crc      <= crc_nib(crc, byte_q[7:4]);
          // No further byte is requested after the last one or at the length
          // limit; the limit case then falls into the abort below.
          tx_ready <= !last_q && (byte_cnt != MAX_C);
        end
        // SFD always offers tx_ready, so last_q is never consulted there.
        S_SFD, S_DHI: begin
          if (tx_ready) begin
            if (tx_valid) begin
              state    <= S_DLO;
              byte_q   <= tx_data;
              last_q   <= tx_last;
              byte_cnt <= byte_cnt_inc;
              phy_txd  <= tx_data[3:0];
              crc      <= crc_nib(crc, tx_data[3:0]);
            end else begin
              state      <= S_ABORT;
              phy_txd    <= 4'h0;
              phy_tx_err <= 1'b1;
            end
          end else if (!last_q) begin
            state      <= S_ABORT;
            phy_txd    <= 4'h0;
            phy_tx_err <= 1'b1;
          end else if (byte_cnt < MIN_C) begin
            state   <= S_PAD;
            pad_hi  <= 1'b0;
            phy_txd <= 4'h0;
            crc     <= crc_nib(crc, 4'h0);
          end else begin
            state   <= S_FCS;
            cnt     <= 16'd0;
            phy_txd <= ~crc[3:0];
            crc     <= crc >> 4;
          end
        end
        S_PAD: begin
          if (!pad_hi) begin
            pad_hi   <= 1'b1;
            byte_cnt <= byte_cnt_inc;
            phy_txd  <= 4'h0;
            crc      <= crc_nib(crc, 4'h0);
          end else if (byte_cnt < MIN_C) begin
            pad_hi  <= 1'b0;
            phy_txd <= 4'h0;
            crc     <= crc_nib(crc, 4'h0);
          end else begin
            state   <= S_FCS;
            cnt     <= 16'd0;
            phy_txd <= ~crc[3:0];
            crc     <= crc >> 4;
          end
        end
        // The CRC register is consumed as a shift register during FCS.
        S_FCS: begin
          if (cnt == 16'd7) begin
            state     <= S_IFG;
            cnt       <= 16'd0;
            phy_tx_en <= 1'b0;
            phy_txd   <= 4'h0;
          end else begin
            cnt     <= cnt + 16'd1;
            phy_txd <= ~crc[3:0];
            crc     <= crc >> 4;
          end
        end
        S_ABORT: begin
          state     <= S_IFG;
          cnt       <= 16'd0;
          phy_tx_en <= 1'b0;
          phy_txd   <= 4'h0;
        end
        S_IFG: begin
          if (cnt == IFG_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          phy_tx_en <= 1'b0;
          phy_txd   <= 4'h0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer. Three instances with different MIN/MAX settings
// share clock, reset, tx_data and tx_last; each has its own tx_valid.
// Expected nibbles are queued when a frame is driven and compared as the
// active instance transmits.
module tb_mii_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic [2:0] tx_valid = 3'b000;

  wire [2:0]      tx_ready;
  wire [2:0]      phy_tx_en;
  wire [2:0]      phy_tx_err;
  wire [2:0]      busy;
  wire [2:0][3:0] phy_txd;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int MINP = (g == 1) ? 60 : 0;
    localparam int MAXP = (g == 2) ? 16 : 1514;
    mii_tx_framer #(.MIN_FRAME(MINP), .MAX_FRAME(MAXP), .IFG_NIBBLES(24)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid[g]),
      .tx_last   (tx_last),
      .tx_ready  (tx_ready[g]),
      .phy_tx_en (phy_tx_en[g]),
      .phy_txd   (phy_txd[g]),
      .phy_tx_err(phy_tx_err[g]),
      .busy      (busy[g])
    );
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [4:0]  exp_q[$];
  logic [7:0]  buf_b [0:63];
  int          act = 0;
  bit          mon_on = 1'b0;
  bit          en_d = 1'b0;
  int          hi_run, lo_run, ifg_run, last_hi, last_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // One cycle: wait for the falling edge, then score the active instance.
  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    if (mon_on) begin
      if (phy_tx_en[act]) begin
        if (exp_q.size() == 0) chk("extra_nibble", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("nibble", {27'h0, phy_tx_err[act], phy_txd[act]}, {27'h0, e});
        end
        if (!en_d) last_gap = lo_run;
        hi_run++;
        lo_run  = 0;
        ifg_run = 0;
      end else begin
        if (phy_tx_err[act]) chk("err_without_en", 1, 0);
        if (en_d) last_hi = hi_run;
        hi_run = 0;
        lo_run++;
        if (busy[act]) ifg_run++;
      end
      en_d = phy_tx_en[act];
    end
  endtask

  task automatic start_test(input int d);
    act = d; en_d = 1'b0;
    hi_run = 0; lo_run = 0; ifg_run = 0; last_hi = 0; last_gap = 0;
    exp_q.delete();
    mon_on = 1'b1;
  endtask

  task automatic push_pre();
    for (int i = 0; i < 15; i++) exp_q.push_back(5'h05);
    exp_q.push_back(5'h0D);
  endtask

  task automatic push_data(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, buf_b[i][3:0]});
      exp_q.push_back({1'b0, buf_b[i][7:4]});
    end
  endtask

  task automatic push_pad(input int nbytes);
    for (int i = 0; i < 2 * nbytes; i++) exp_q.push_back(5'h00);
  endtask

  task automatic push_fcs(input logic [31:0] fcs);
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, fcs[4*k +: 4]});
  endtask

  // Byte-wise reference CRC over buf_b[0:n-1] zero-padded to padto bytes.
  function automatic logic [31:0] fcs_of(input int n, input int padto);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    c   = 32'hFFFFFFFF;
    tot = (n > padto) ? n : padto;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? buf_b[i] : 8'h00;
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Offers buf_b[0:n-1]; a byte counts as taken on the edge after a cycle
  // that showed tx_ready && tx_valid, and the next byte is shown afterwards.
  task automatic send_bytes(input int d, input int n, input bit with_last, input bit hold);
    int i, guard;
    bit pend;
    i = 0; guard = 0; pend = 1'b0;
    tx_data = buf_b[0];
    tx_last = with_last && (n == 1);
    tx_valid[d] = 1'b1;
    while (i < n) begin
      tick();
      guard++;
      if (guard > 3000) begin
        chk("send_timeout", i, n);
        break;
      end
      if (pend) begin
        pend = 1'b0;
        i++;
        tx_data = buf_b[i];
        tx_last = with_last && (i == n - 1);
        if (i == n && !hold) tx_valid[d] = 1'b0;
      end else if (tx_ready[d] && tx_valid[d]) begin
        pend = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    tick();
    while (busy[d] && guard < 3000) begin
      tick();
      guard++;
    end
    if (busy[d]) chk("idle_timeout", 1, 0);
  endtask

  task automatic load_123456789();
    for (int i = 0; i < 9; i++) buf_b[i] = 8'h31 + 8'(i);
  endtask

  bit seen;

  initial begin
    for (int i = 0; i < 64; i++) buf_b[i] = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", tx_ready[d], 0);
      chk("rst_en", phy_tx_en[d], 0);
      chk("rst_txd", phy_txd[d], 0);
      chk("rst_err", phy_tx_err[d], 0);
      chk("rst_busy", busy[d], 0);
    end
    rst = 1'b0;
    tick();

    // "123456789" with no padding: known FCS 0xCBF43926
    start_test(0);
    load_123456789();
    push_pre(); push_data(9); push_fcs(32'hCBF43926);
    send_bytes(0, 9, 1'b1, 1'b0);
    wait_idle(0);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_en_len", last_hi, 42);
    chk("t1_ifg", ifg_run, 24);

    // one byte padded to 60
    start_test(1);
    buf_b[0] = 8'hAB;
    push_pre(); push_data(1); push_pad(59); push_fcs(fcs_of(1, 60));
    send_bytes(1, 1, 1'b1, 1'b0);
    wait_idle(1);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_en_len", last_hi, 144);
    chk("t2_ifg", ifg_run, 24);

    // underrun after three bytes
    start_test(0);
    buf_b[0] = 8'hE7; buf_b[1] = 8'h18; buf_b[2] = 8'h96;
    push_pre(); push_data(3); exp_q.push_back(5'h10);
    send_bytes(0, 3, 1'b0, 1'b0);
    wait_idle(0);
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_en_len", last_hi, 23);
    chk("t3_ifg", ifg_run, 24);

    // back-to-back frames with tx_valid held high
    start_test(0);
    buf_b[0] = 8'h10; buf_b[1] = 8'h21;
    push_pre(); push_data(2); push_fcs(fcs_of(2, 0));
    send_bytes(0, 2, 1'b1, 1'b1);
    buf_b[0] = 8'h5A; buf_b[1] = 8'hC3; buf_b[2] = 8'h7E;
    push_pre(); push_data(3); push_fcs(fcs_of(3, 0));
    send_bytes(0, 3, 1'b1, 1'b0);
    wait_idle(0);
    chk("t4_q_empty", exp_q.size(), 0);
    chk("t4_gap", last_gap, 25);
    chk("t4_en_len", last_hi, 16 + 6 + 8);

    // reset in the middle of DATA, then a clean frame
    mon_on = 1'b0;
    for (int i = 0; i < 5; i++) buf_b[i] = 8'hF0 + 8'(i);
    send_bytes(0, 2, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_rst_en", phy_tx_en[0], 0);
    chk("t5_rst_txd", phy_txd[0], 0);
    chk("t5_rst_ready", tx_ready[0], 0);
    chk("t5_rst_err", phy_tx_err[0], 0);
    chk("t5_rst_busy", busy[0], 0);
    tx_valid[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start_test(0);
    load_123456789();
    push_pre(); push_data(9); push_fcs(32'hCBF43926);
    send_bytes(0, 9, 1'b1, 1'b0);
    wait_idle(0);
    chk("t5_q_empty", exp_q.size(), 0);
    chk("t5_en_len", last_hi, 42);

    // overlength: MAX_FRAME=16, stream keeps offering bytes without tx_last
    start_test(2);
    for (int i = 0; i < 20; i++) buf_b[i] = 8'h40 + 8'(i * 7);
    push_pre(); push_data(16); exp_q.push_back(5'h10);
    send_bytes(2, 16, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (phy_tx_err[2]) seen = 1'b1;
    end
    tx_valid[2] = 1'b0;
    chk("t6_err_seen", seen, 1);
    wait_idle(2);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_en_len", last_hi, 49);
    chk("t6_ifg", ifg_run, 24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
